// File: rtl/snake_field_scanner.sv
// snake_field_scanner: reader side of the 8x8 snake field.
// Fetches one row (8 cells) into a shadow register, lights it on a
// row-multiplexed LED matrix for DWELL cycles, blinks food cells every
// BLINK_FRAMES frames and pulses frame_done after each complete frame.
module snake_field_scanner #(
  parameter int unsigned DWELL        = 1000,  // cycles each row stays lit, 1..65535
  parameter int unsigned BLINK_FRAMES = 16     // frames between food blink toggles, 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rd_en,
  output logic [5:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic [7:0] row_sel,
  output logic [7:0] col_on,
  output logic       frame_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DWELL
  } state_e;

  localparam logic [15:0] DWELL_LAST  = 16'(DWELL - 1);
  localparam logic [7:0]  BLINK_LIMIT = 8'(BLINK_FRAMES);
  localparam logic [3:0]  FETCH_LAST  = 4'd8;
  localparam logic [2:0]  ROW_LAST    = 3'd7;

  // Cell codes written by the snake engine.
  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_BODY  = 2'd1;
  localparam logic [1:0] CELL_HEAD  = 2'd2;
  localparam logic [1:0] CELL_FOOD  = 2'd3;

  state_e      state_q,      state_d;
  logic [2:0]  row_q,        row_d;
  logic [3:0]  fidx_q,       fidx_d;        // FETCH cycle index F0..F8
  logic [15:0] dwell_cnt_q,  dwell_cnt_d;
  logic [7:0]  frame_cnt_q,  frame_cnt_d;
  logic        food_vis_q,   food_vis_d;
  logic [7:0]  shadow_q,     shadow_d;

  logic        rd_en_q,      rd_en_d;
  logic [5:0]  rd_addr_q,    rd_addr_d;
  logic [7:0]  row_sel_q,    row_sel_d;
  logic [7:0]  col_on_q,     col_on_d;
  logic        frame_done_q, frame_done_d;
  logic        busy_q,       busy_d;

  logic [2:0]  cap_idx;

  // A cell lights for body and head; food follows the blink phase.
  function automatic logic cell_lit(input logic [1:0] code, input logic vis);
    case (code)
      CELL_BODY, CELL_HEAD: cell_lit = 1'b1;
      CELL_FOOD:            cell_lit = vis;
      CELL_EMPTY:           cell_lit = 1'b0;
      default:              cell_lit = 1'b0;
    endcase
  endfunction

  // Read data for cell F(k-1) arrives during FETCH cycle Fk.
  assign cap_idx = 3'(fidx_q - 4'd1);

  // Next-state and next-output computation for the scan sequencer.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    row_d        = row_q;
    fidx_d       = fidx_q;
    dwell_cnt_d  = dwell_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    food_vis_d   = food_vis_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_FETCH;
          fidx_d  = 4'd0;
        end
      end

      ST_FETCH: begin
        if (fidx_q != 4'd0) begin
          shadow_d[cap_idx] = cell_lit(rd_data, food_vis_q);
        end
        if (fidx_q == FETCH_LAST) begin
          state_d     = ST_DWELL;
          dwell_cnt_d = 16'd0;
        end else begin
          fidx_d = fidx_q + 4'd1;
        end
      end

      ST_DWELL: begin
        if (dwell_cnt_q == DWELL_LAST) begin
          dwell_cnt_d = 16'd0;
          fidx_d      = 4'd0;
          if (row_q != ROW_LAST) begin
            // Mid-frame rows ignore en: a started frame always completes.
            row_d   = row_q + 3'd1;
            state_d = ST_FETCH;
          end else begin
            row_d        = 3'd0;
            frame_done_d = 1'b1;
            if (frame_cnt_q + 8'd1 == BLINK_LIMIT) begin
              frame_cnt_d = 8'd0;
              food_vis_d  = ~food_vis_q;
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
            state_d = en ? ST_FETCH : ST_IDLE;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q + 16'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state and
    // line up with the state they describe.
    rd_en_d   = (state_d == ST_FETCH) && (fidx_d != FETCH_LAST);
    rd_addr_d = rd_en_d ? {row_d, fidx_d[2:0]} : rd_addr_q;
    row_sel_d = (state_d == ST_DWELL) ? (8'b1 << row_d) : 8'd0;
    col_on_d  = (state_d == ST_DWELL) ? shadow_d : 8'd0;
    busy_d    = (state_d != ST_IDLE);
  end

  // State, shadow row and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= ST_IDLE;
      row_q        <= 3'd0;
      fidx_q       <= 4'd0;
      dwell_cnt_q  <= 16'd0;
      frame_cnt_q  <= 8'd0;
      food_vis_q   <= 1'b1;
      // NOTE: the shadow row is a small register, not a RAM, so it is reset
      // along with everything else and never shows stale cells.
      shadow_q     <= 8'd0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= 6'd0;
      row_sel_q    <= 8'd0;
      col_on_q     <= 8'd0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      fidx_q       <= fidx_d;
      dwell_cnt_q  <= dwell_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      food_vis_q   <= food_vis_d;
      shadow_q     <= shadow_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      row_sel_q    <= row_sel_d;
      col_on_q     <= col_on_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign row_sel    = row_sel_q;
  assign col_on     = col_on_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_snake_field_scanner.sv
// Self-checking bench for snake_field_scanner: directed scenarios plus a
// randomized phase, all checked against a timeline reference model.
module tb_snake_field_scanner;

  localparam int DW  = 4;
  localparam int BF  = 2;
  localparam int ROW_PERIOD = 9 + DW;

  logic       clk;
  logic       rst;
  logic       en;
  logic       rd_en;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic [7:0] row_sel;
  logic [7:0] col_on;
  logic       frame_done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  bit [1:0] mem [64];

  snake_field_scanner #(.DWELL(DW), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .row_sel    (row_sel),
    .col_on     (col_on),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Field memory: data for a read appears one cycle after rd_en, garbage otherwise.
  always @(posedge clk) begin
    rd_data <= rd_en ? mem[rd_addr] : 2'($urandom);
  end

  // ---------------- reference model ----------------
  // Scan is a timeline: each row is a 13-cycle period (8 reads, 1 blank,
  // DW lit); the food phase depends only on frames completed since reset.
  bit       m_valid  = 0;
  bit       m_active = 0;
  int       m_row    = 0;
  int       m_pos    = 0;
  int       m_frames = 0;
  bit       m_fd     = 0;
  bit [7:0] m_pat    = 0;

  function automatic bit lit(input bit [1:0] code, input bit vis);
    if (code == 2'd1 || code == 2'd2) return 1'b1;
    if (code == 2'd3) return vis;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    bit vis;
    vis = ((m_frames / BF) % 2) == 0;
    if (m_valid) begin
      if (!m_active) begin
        check("m_idle_rd_en", rd_en, 0);
        check("m_idle_row_sel", row_sel, 0);
        check("m_idle_col_on", col_on, 0);
        check("m_idle_busy", busy, 0);
      end else begin
        check("m_busy", busy, 1);
        if (m_pos < 8) begin
          check("m_fetch_rd_en", rd_en, 1);
          check("m_fetch_rd_addr", rd_addr, m_row * 8 + m_pos);
          check("m_fetch_row_sel", row_sel, 0);
          check("m_fetch_col_on", col_on, 0);
          m_pat[m_pos] = lit(mem[m_row * 8 + m_pos], vis);
        end else if (m_pos == 8) begin
          check("m_blank_rd_en", rd_en, 0);
          check("m_blank_row_sel", row_sel, 0);
          check("m_blank_col_on", col_on, 0);
        end else begin
          check("m_dwell_rd_en", rd_en, 0);
          check("m_dwell_row_sel", row_sel, 8'b1 << m_row);
          check("m_dwell_col_on", col_on, m_pat);
        end
      end
      check("m_frame_done", frame_done, m_fd);
    end
    // advance to the next cycle using the inputs the DUT will sample
    if (rst) begin
      m_valid  = 1;
      m_active = 0;
      m_row    = 0;
      m_pos    = 0;
      m_frames = 0;
      m_fd     = 0;
    end else if (m_valid) begin
      m_fd = 0;
      if (!m_active) begin
        if (en) begin
          m_active = 1;
          m_pos    = 0;
        end
      end else begin
        m_pos++;
        if (m_pos == ROW_PERIOD) begin
          m_pos = 0;
          if (m_row < 7) begin
            m_row++;
          end else begin
            m_row = 0;
            m_frames++;
            m_fd = 1;
            m_active = en;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int n;
    bit saw_fd;
    bit saw_row7;
    bit [5:0] exp_vis;
    logic [7:0] prev;
    logic [7:0] seq [$];

    rst = 1'b1;
    en  = 1'b0;
    foreach (mem[i]) mem[i] = 2'd0;

    // Reset and idle
    repeat (3) tick;
    rst = 1'b0;
    check("rst_rd_en", rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_row_sel", row_sel, 0);
    check("rst_col_on", col_on, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_rd_addr", rd_addr, 0);
    repeat (20) tick;
    check("idle_busy", busy, 0);
    check("idle_rd_en", rd_en, 0);

    // Single-row fetch: row 0 = {0,1,2,3,0,0,1,0}
    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2; mem[3] = 2'd3;
    mem[4] = 2'd0; mem[5] = 2'd0; mem[6] = 2'd1; mem[7] = 2'd0;
    en = 1'b1;
    tick;
    for (int k = 0; k < 8; k++) begin
      check("row0_rd_en", rd_en, 1);
      check("row0_rd_addr", rd_addr, k);
      check("row0_blank", row_sel, 0);
      tick;
    end
    check("row0_f8_rd_en", rd_en, 0);
    check("row0_f8_row_sel", row_sel, 0);
    tick;
    for (int d = 0; d < DW; d++) begin
      check("row0_dwell_sel", row_sel, 8'h01);
      check("row0_dwell_col", col_on, 8'b0100_1110);
      tick;
    end
    check("row1_rd_addr", rd_addr, 8);
    check("row1_rd_en", rd_en, 1);
    check("row1_blank", row_sel, 0);

    // Frame timing and row sequence
    n = 0;
    while (frame_done !== 1'b1 && n < 300) begin tick; n++; end
    check("wait_fd1", n < 300, 1);
    prev = row_sel;
    n = 0;
    do begin
      tick;
      n++;
      if (row_sel !== prev) seq.push_back(row_sel);
      prev = row_sel;
    end while (frame_done !== 1'b1 && n < 300);
    check("frame_period", n, 8 * ROW_PERIOD);
    check("row_seq_len", seq.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < seq.size())
        check("row_seq", seq[i], (i % 2 == 0) ? (8'b1 << (i / 2)) : 8'h00);
    end

    // Enable drop during row 2 dwell
    n = 0;
    while (row_sel !== 8'h04 && n < 300) begin tick; n++; end
    check("wait_row2", n < 300, 1);
    en = 1'b0;
    saw_fd = 0;
    saw_row7 = 0;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick;
      n++;
      if (frame_done === 1'b1) saw_fd = 1;
      if (row_sel === 8'h80) saw_row7 = 1;
    end
    check("drop_idle", n < 300, 1);
    check("drop_saw_row7", saw_row7, 1);
    check("drop_saw_fd", saw_fd, 1);
    check("drop_row_sel", row_sel, 0);
    check("drop_col_on", col_on, 0);
    repeat (5) tick;
    check("drop_stays_idle", busy, 0);

    // Food blink: only (3,5) holds food
    rst = 1'b1;
    tick;
    rst = 1'b0;
    foreach (mem[i]) mem[i] = 2'd0;
    mem[3 * 8 + 5] = 2'd3;
    en = 1'b1;
    exp_vis = 6'b110011;
    for (int f = 0; f < 6; f++) begin
      n = 0;
      while (row_sel !== 8'h08 && n < 300) begin tick; n++; end
      check("blink_wait_row3", n < 300, 1);
      check("blink_col5", col_on[5], exp_vis[f]);
      check("blink_other_cols", col_on & 8'hDF, 0);
      n = 0;
      while (frame_done !== 1'b1 && n < 300) begin tick; n++; end
      check("blink_wait_fd", n < 300, 1);
    end

    // Reset at FETCH F4 of row 5 while food is hidden
    n = 0;
    while (!(rd_en === 1'b1 && rd_addr === 6'd44) && n < 300) begin tick; n++; end
    check("wait_row5_f4", n < 300, 1);
    rst = 1'b1;
    tick;
    check("mid_rst_rd_en", rd_en, 0);
    check("mid_rst_row_sel", row_sel, 0);
    check("mid_rst_col_on", col_on, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_done", frame_done, 0);
    rst = 1'b0;
    tick;
    check("restart_rd_en", rd_en, 1);
    check("restart_rd_addr", rd_addr, 0);
    n = 0;
    while (row_sel !== 8'h08 && n < 300) begin tick; n++; end
    check("restart_wait_row3", n < 300, 1);
    check("restart_food_vis", col_on[5], 1);

    // Randomized phase: field edits, enable toggles, rare resets
    for (int c = 0; c < 4000; c++) begin
      tick;
      if (rst) rst = 1'b0;
      if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 63)] = 2'($urandom);
      if ($urandom_range(0, 149) == 0) en = ~en;
      if ($urandom_range(0, 1499) == 0) rst = 1'b1;
    end
    rst = 1'b0;
    repeat (2) tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
